mmio_master: RTL
================

MMIO_MASTER -- requirements
Module: mmio_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: number of WAIT cycles without ah_mmack before a request is abandoned.
REQ-002 ha_pclock  in  1  sole clock; all state changes on its rising edge.
REQ-003 ha_reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid/req_ready  in/out  1/1  host request handshake; a transfer occurs when both are 1 on a clock edge.
REQ-005 req_cfg, req_rnw, req_dw  in  1 each  descriptor-space select, 1=read/0=write, 1=doubleword/0=word.
REQ-006 req_addr  in  [0:23]  MMIO address; req_wdata  in  [0:63]  write data.
REQ-007 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  [0:63]; rsp_status  out  2 (00 OK, 01 TIMEOUT, 10 PARITY).
REQ-008 ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw  out  1 each  MMIO request to AFU.
REQ-009 ha_mmad  out  [0:23]; ha_mmadpar  out  1; ha_mmdata  out  [0:63]; ha_mmdatapar  out  1.
REQ-010 ah_mmack  in  1; ah_mmdata  in  [0:63]; ah_mmdatapar  in  1  AFU completion and read data.
REQ-011 stray_ack  out  1  sticky flag: ah_mmack seen outside WAIT.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT, RESP; one request outstanding at a time.
REQ-013 IDLE: req_ready=1; on req_valid capture all req_* fields, go to ISSUE; otherwise stay.
REQ-014 ISSUE: ha_mmval=1 for exactly one cycle with the captured fields on ha_mm*, then go to WAIT.
REQ-015 ha_mmcfg/rnw/dw/ad/data hold the captured values from ISSUE through RESP; ha_mmval is 0 in every state except ISSUE.
REQ-016 ha_mmadpar = odd parity of ha_mmad; ha_mmdatapar = odd parity of ha_mmdata (XNOR-reduce).
REQ-017 WAIT: a timeout counter starts at 0 on entry and increments each cycle; ah_mmack=1 leads to RESP with ah_mmdata and ah_mmdatapar captured that edge.
REQ-018 WAIT: when the counter reaches TIMEOUT_CYCLES-1 with no ack, go to RESP with status TIMEOUT and rdata 0.
REQ-019 WAIT: an ack arriving on the same cycle as the timeout terminal count takes priority and completes as an ack.
REQ-020 RESP: rsp_valid=1 for one cycle, then return to IDLE; req_ready=0 in ISSUE, WAIT and RESP.
REQ-021 rsp_rdata = captured ah_mmdata for reads and 0 for writes; it is held until the next RESP.
REQ-022 Word reads pass all 64 bits through unmodified.
REQ-023 ah_mmack in IDLE, ISSUE or RESP is ignored for completion and sets stray_ack, which stays set until reset.
REQ-024 The counter width is clog2(TIMEOUT_CYCLES)+1 bits and it does not wrap.

Reset
REQ-025 Asserting ha_reset at any time, including mid-transaction, forces IDLE and clears the counter and stray_ack; no rsp_valid is produced for the aborted request.
REQ-026 Reset values: req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_status=00; all ha_mm* outputs 0 except the parity bits, which are 1 (odd parity of zero).

Configuration
REQ-027 Macro MMIO_MASTER_PARCHK_EN.
- Defined: on a read ack, an ah_mmdatapar mismatch against odd parity of ah_mmdata gives rsp_status PARITY (10); rdata is still returned.
- Undefined: no check is made, rsp_status is never 10, and ah_mmdatapar is unused.

Structure
REQ-028 Shared package mmio_pkg holds the FSM state enum, the rsp_status code constants and an odd-parity function used for both generation and checking.
REQ-029 Single natural sub-module: mmio_timeout, the WAIT counter with clear/enable inputs and a terminal-count output.

Verification
REQ-030 Write: cfg=0, rnw=0, addr=0x000010, wdata=0x0123456789ABCDEF; AFU acks 3 cycles after ha_mmval.
- ha_mmval is high for exactly 1 cycle.
- ha_mmadpar=0, ha_mmdatapar=1.
- rsp_valid pulses once with status 00 and rdata 0.
REQ-031 Descriptor read: cfg=1, rnw=1, addr=0x0; AFU returns 0x0000000100010010 with correct odd parity.
- rsp_rdata=0x0000000100010010, status 00.
REQ-032 Timeout: AFU never acks, TIMEOUT_CYCLES=8.
- rsp_valid occurs exactly 8 cycles after WAIT entry, with status 01 and rdata 0.
- Ack on the 8th WAIT cycle instead gives status 00.
REQ-033 Parity (PARCHK_EN defined): read acked with ah_mmdata=0x1 and ah_mmdatapar=1.
- Status 10, rdata 0x1.
- With the macro undefined, the same stimulus gives status 00.
REQ-034 Stray/reset: ack pulsed while IDLE sets stray_ack with no rsp_valid.
- ha_reset asserted in WAIT gives IDLE and req_ready=1 on the next edge, with no rsp_valid and stray_ack cleared.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO master: FSM states, response codes and
// the odd-parity helper used for both parity generation and checking.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } mmio_state_e;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_TIMEOUT = 2'b01;
  localparam logic [1:0] RSP_PARITY  = 2'b10;

  // Odd parity bit for up to 64 bits; zero-extend narrower fields
  function automatic logic odd_parity(input logic [63:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/mmio_timeout.sv
// WAIT-state timeout counter: cleared outside WAIT, counts while enabled,
// saturates at the terminal count instead of wrapping.
module mmio_timeout
  import mmio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic ha_pclock,
  input  logic ha_reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             tc_s;

  assign tc_s = (cnt_r == TC_VAL);
  assign tc   = tc_s;

  // Counter register; holds once the terminal count is reached
  always_ff @(posedge ha_pclock or posedge ha_reset) begin
    if (ha_reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && !tc_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mmio_master.sv
// Single-outstanding MMIO request master toward an AFU.
// Optional read-data parity checking is enabled by defining MMIO_MASTER_PARCHK_EN.
module mmio_master
  import mmio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        ha_pclock,
  input  logic        ha_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_cfg,
  input  logic        req_rnw,
  input  logic        req_dw,
  input  logic [0:23] req_addr,
  input  logic [0:63] req_wdata,
  output logic        rsp_valid,
  output logic [0:63] rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic        ha_mmval,
  output logic        ha_mmcfg,
  output logic        ha_mmrnw,
  output logic        ha_mmdw,
  output logic [0:23] ha_mmad,
  output logic        ha_mmadpar,
  output logic [0:63] ha_mmdata,
  output logic        ha_mmdatapar,
  input  logic        ah_mmack,
  input  logic [0:63] ah_mmdata,
  input  logic        ah_mmdatapar,
  output logic        stray_ack
);

  mmio_state_e state_r;
  mmio_state_e state_nxt_s;
  logic        tc_s;
  logic        in_wait_s;
  logic        par_err_s;
  logic [0:63] rdata_nxt_s;
  logic [1:0]  status_nxt_s;

  assign in_wait_s = (state_r == ST_WAIT);

`ifdef MMIO_MASTER_PARCHK_EN
  assign par_err_s = ha_mmrnw && (ah_mmdatapar != odd_parity(ah_mmdata));
`else
  logic unused_datapar_s;
  assign unused_datapar_s = ah_mmdatapar;
  assign par_err_s        = 1'b0;
`endif

  mmio_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .ha_pclock(ha_pclock),
    .ha_reset (ha_reset),
    .clr      (!in_wait_s),
    .en       (in_wait_s),
    .tc       (tc_s)
  );

  // State register
  always_ff @(posedge ha_pclock or posedge ha_reset) begin
    if (ha_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and completion result; an ack beats the terminal count
  always_comb begin
    state_nxt_s  = state_r;
    rdata_nxt_s  = rsp_rdata;
    status_nxt_s = rsp_status;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (ah_mmack) begin
          state_nxt_s  = ST_RESP;
          rdata_nxt_s  = ha_mmrnw ? ah_mmdata : 64'd0;
          status_nxt_s = par_err_s ? RSP_PARITY : RSP_OK;
        end else if (tc_s) begin
          state_nxt_s  = ST_RESP;
          rdata_nxt_s  = 64'd0;
          status_nxt_s = RSP_TIMEOUT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Registered handshake strobes and response payload
  always_ff @(posedge ha_pclock or posedge ha_reset) begin
    if (ha_reset) begin
      req_ready  <= 1'b1;
      ha_mmval   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 64'd0;
      rsp_status <= RSP_OK;
    end else begin
      req_ready  <= (state_nxt_s == ST_IDLE);
      ha_mmval   <= (state_nxt_s == ST_ISSUE);
      rsp_valid  <= (state_nxt_s == ST_RESP);
      rsp_rdata  <= rdata_nxt_s;
      rsp_status <= status_nxt_s;
    end
  end

  // Request capture; these registers drive ha_mm* until the next accept
  always_ff @(posedge ha_pclock or posedge ha_reset) begin
    if (ha_reset) begin
      ha_mmcfg     <= 1'b0;
      ha_mmrnw     <= 1'b0;
      ha_mmdw      <= 1'b0;
      ha_mmad      <= 24'd0;
      ha_mmadpar   <= 1'b1;
      ha_mmdata    <= 64'd0;
      ha_mmdatapar <= 1'b1;
    end else if ((state_r == ST_IDLE) && req_valid) begin
      ha_mmcfg     <= req_cfg;
      ha_mmrnw     <= req_rnw;
      ha_mmdw      <= req_dw;
      ha_mmad      <= req_addr;
      ha_mmadpar   <= odd_parity({40'd0, req_addr});
      ha_mmdata    <= req_wdata;
      ha_mmdatapar <= odd_parity(req_wdata);
    end
  end

  // Sticky flag for acks that arrive when nothing is awaiting one
  always_ff @(posedge ha_pclock or posedge ha_reset) begin
    if (ha_reset) begin
      stray_ack <= 1'b0;
    end else if (ah_mmack && !in_wait_s) begin
      stray_ack <= 1'b1;
    end
  end

endmodule
